// File: rtl/counter_pwm_pkg.sv
// Shared definitions for the counter-driven PWM block and its helpers.
package counter_pwm_pkg;

  // Count bus width shared with the free-running up-counter.
  localparam int CNT_WIDTH = 8;

  // Output polarity selectors.
  localparam bit POL_ACTIVE_HIGH = 1'b1;
  localparam bit POL_ACTIVE_LOW  = 1'b0;

  // Controller state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/counter_wrap_detect.sv
// Detects a period boundary on a counter bus: any decrease between two
// consecutive samples (natural overflow or an upstream counter reset).
module counter_wrap_detect
  import counter_pwm_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_prev_q;
  logic             prev_valid_q;

  // Keep the previous sample; the first sample after reset has no history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_prev_q <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      count_prev_q <= count;
      prev_valid_q <= 1'b1;
    end
  end

  // Equal consecutive values (stalled counter) are not a boundary.
  assign wrap = prev_valid_q && (count < count_prev_q);

endmodule

// File: rtl/counter_pwm.sv
// Converts a free-running count into a registered PWM waveform. The duty
// value arrives through a one-deep shadow register and only takes effect
// at a period boundary so the waveform never glitches mid-period.
module counter_pwm
  import counter_pwm_pkg::*;
#(
  parameter int               WIDTH      = CNT_WIDTH,
  parameter logic [WIDTH-1:0] DUTY_RESET = '0,
  parameter bit               POLARITY   = POL_ACTIVE_HIGH,
  parameter int               WRAP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      count,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      duty_data,
  input  logic                  duty_valid,
  output logic                  duty_ready,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic [WRAP_CNT_W-1:0] period_cnt,
  output logic                  running
);

  pwm_state_e            state_q, state_d;
  logic                  wrap;
  logic                  period_evt;
  logic                  duty_load;
  logic                  duty_xfer;
  logic [WIDTH-1:0]      duty_eff;
  logic [WIDTH-1:0]      duty_active_q;
  logic [WIDTH-1:0]      pending_q;
  logic                  pending_full_q;
  logic                  pwm_d, pwm_q;
  logic                  period_start_q;
  logic [WRAP_CNT_W-1:0] period_cnt_q, period_cnt_d;

  counter_wrap_detect #(.WIDTH(WIDTH)) u_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .count   (count),
    .wrap    (wrap)
  );

  // A boundary only counts while enabled and out of IDLE; a falling enable wins.
  assign period_evt = wrap && enable && (state_q != IDLE);
  assign duty_load  = period_evt && pending_full_q;
  assign duty_xfer  = duty_valid && !pending_full_q;
  // The duty loaded on a boundary already applies to that cycle's compare.
  assign duty_eff   = duty_load ? pending_q : duty_active_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: disable overrides everything; SYNC waits for a boundary.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (wrap) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: PWM compare and saturating period count for the next cycle.
  always_comb begin
    pwm_d        = !POLARITY;
    period_cnt_d = period_cnt_q;
    if (state_d == RUN) begin
      pwm_d = (count < duty_eff) ? POLARITY : !POLARITY;
    end
    if (state_d == IDLE) begin
      period_cnt_d = '0;
    end else if (period_evt && (period_cnt_q != {WRAP_CNT_W{1'b1}})) begin
      period_cnt_d = period_cnt_q + 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q          <= !POLARITY;
      period_start_q <= 1'b0;
      period_cnt_q   <= '0;
    end else begin
      pwm_q          <= pwm_d;
      period_start_q <= period_evt;
      period_cnt_q   <= period_cnt_d;
    end
  end

  // Shadow and active duty: consume on a boundary first, then capture a new write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_active_q  <= DUTY_RESET;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
    end else begin
      if (duty_load) begin
        duty_active_q  <= pending_q;
        pending_full_q <= 1'b0;
      end
      if (duty_xfer) begin
        pending_q      <= duty_data;
        pending_full_q <= 1'b1;
      end
    end
  end

  assign duty_ready   = !pending_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign period_cnt   = period_cnt_q;
  assign running      = (state_q == RUN);

endmodule

// File: tb/tb_counter_pwm.sv
// Scoreboard bench for counter_pwm: a cycle model pushes expected outputs
// when inputs are driven; they are popped and compared after the edge.
// A second instance with inverted polarity shares all inputs.
module tb_counter_pwm;
  localparam int W  = 8;
  localparam int PW = 16;
  localparam int S_IDLE = 0, S_SYNC = 1, S_RUN = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  count = '0;
  logic          enable = 1'b0;
  logic [W-1:0]  duty_data = '0;
  logic          duty_valid = 1'b0;
  logic          duty_ready, pwm_out, period_start, running;
  logic [PW-1:0] period_cnt;
  logic          duty_ready_n, pwm_out_n, period_start_n, running_n;
  logic [PW-1:0] period_cnt_n;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          pwm;
    logic          ps;
    logic          run;
    logic          rdy;
    logic [PW-1:0] pcnt;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int            m_state;
  logic [W-1:0]  m_prev, m_duty, m_pend;
  bit            m_pvalid, m_pfull;
  int unsigned   m_pcnt;

  always #5 clk = ~clk;

  counter_pwm #(.WIDTH(W), .DUTY_RESET(8'd0), .POLARITY(1'b1), .WRAP_CNT_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .count(count), .enable(enable),
    .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(duty_ready),
    .pwm_out(pwm_out), .period_start(period_start), .period_cnt(period_cnt),
    .running(running)
  );

  counter_pwm #(.WIDTH(W), .DUTY_RESET(8'd0), .POLARITY(1'b0), .WRAP_CNT_W(PW)) dut_inv (
    .clk(clk), .reset_n(reset_n), .count(count), .enable(enable),
    .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(duty_ready_n),
    .pwm_out(pwm_out_n), .period_start(period_start_n), .period_cnt(period_cnt_n),
    .running(running_n)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t count=%0d)", tag, got, exp, $time, count);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_prev = '0; m_duty = 8'd0; m_pend = '0;
    m_pvalid = 0; m_pfull = 0; m_pcnt = 0;
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pwm"}, pwm_out, 0);
    check_val({tag, "_pwm_inv"}, pwm_out_n, 1);
    check_val({tag, "_ready"}, duty_ready, 1);
    check_val({tag, "_pcnt"}, period_cnt, 0);
    check_val({tag, "_running"}, running, 0);
    check_val({tag, "_ps"}, period_start, 0);
  endtask

  // One clock: model the cycle, push expectation, clock, pop and compare.
  task automatic step();
    exp_t e;
    bit wrap, xfer, evt, load;
    int ns;
    logic [W-1:0] eff;
    wrap = m_pvalid && (count < m_prev);
    xfer = duty_valid && !m_pfull;
    evt  = enable && (m_state != S_IDLE) && wrap;
    if (!enable)                          ns = S_IDLE;
    else if (m_state == S_IDLE)           ns = S_SYNC;
    else if (m_state == S_SYNC && wrap)   ns = S_RUN;
    else                                  ns = m_state;
    load  = evt && m_pfull;
    eff   = load ? m_pend : m_duty;
    e.pwm = (ns == S_RUN) && (count < eff);
    e.ps  = evt;
    if (ns == S_IDLE) m_pcnt = 0;
    else if (evt && m_pcnt != 32'hFFFF) m_pcnt++;
    e.pcnt = m_pcnt[PW-1:0];
    if (load) begin m_duty = m_pend; m_pfull = 0; end
    if (xfer) begin m_pend = duty_data; m_pfull = 1; end
    e.rdy = !m_pfull;
    e.run = (ns == S_RUN);
    m_state = ns; m_prev = count; m_pvalid = 1;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_val("pwm", pwm_out, e.pwm);
    check_val("pwm_inv", pwm_out_n, !e.pwm);
    check_val("period_start", period_start, e.ps);
    check_val("period_cnt", period_cnt, e.pcnt);
    check_val("running", running, e.run);
    check_val("duty_ready", duty_ready, e.rdy);
    check_val("duty_ready_inv", duty_ready_n, e.rdy);
    if (xfer) begin
      $display("duty write %0d accepted at count %0d", duty_data, count);
      duty_valid = 1'b0;
    end
    count = count + 1'b1;
  endtask

  task automatic run_until(input logic [W-1:0] val);
    int g = 0;
    while (count != val && g < 600) begin step(); g++; end
    check_val("run_until_reached", count, val);
  endtask

  task automatic start_write(input logic [W-1:0] val);
    duty_data  = val;
    duty_valid = 1'b1;
  endtask

  task automatic wait_xfer();
    int g = 0;
    while (duty_valid && g < 1200) begin step(); g++; end
    check_val("write_accepted", duty_valid, 0);
  endtask

  // Measure one full period between period_start pulses on both instances.
  task automatic measure_period(input int exp_hi);
    int g = 0, hi = 0, hi_n = 0, len = 0;
    while (!period_start && g < 600) begin step(); g++; end
    check_val("period_start_seen", period_start, 1);
    do begin
      hi += pwm_out; hi_n += pwm_out_n; len++;
      step();
    end while (!period_start && len < 600);
    check_val("period_len", len, 256);
    check_val("hi_cycles", hi, exp_hi);
    check_val("hi_cycles_inv", hi_n, 256 - exp_hi);
    $display("period measured: len=%0d high=%0d inv_high=%0d expected_high=%0d", len, hi, hi_n, exp_hi);
  endtask

  initial begin
    model_reset();
    // Reset and hold
    #20;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic PWM at duty 64
    start_write(8'd64);
    wait_xfer();
    enable = 1'b1;
    measure_period(64);
    measure_period(64);

    // Shadow update mid-period
    run_until(8'd100);
    start_write(8'd200);
    step();
    check_val("shadow_ready_low", duty_ready, 0);
    measure_period(200);

    // Upstream reset mid-period with a stalled second write
    run_until(8'd10);
    start_write(8'd30);
    wait_xfer();
    start_write(8'd90);
    run_until(8'd120);
    check_val("stall_valid_held", duty_valid, 1);
    check_val("stall_ready_low", duty_ready, 0);
    step();
    count = '0;
    step();
    check_val("upstream_wrap_ps", period_start, 1);
    measure_period(30);
    measure_period(90);

    // Extremes
    start_write(8'd0);
    wait_xfer();
    measure_period(0);
    start_write(8'd255);
    wait_xfer();
    measure_period(255);

    // Disable mid-run, write while idle, re-enable
    run_until(8'd80);
    enable = 1'b0;
    step();
    check_val("disable_running", running, 0);
    check_val("disable_pcnt", period_cnt, 0);
    start_write(8'd128);
    wait_xfer();
    for (int i = 0; i < 300; i++) step();
    enable = 1'b1;
    measure_period(128);

    // Async reset mid-period with a pending write
    run_until(8'd40);
    start_write(8'd77);
    wait_xfer();
    run_until(8'd50);
    step();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    duty_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("async_hold");
    reset_n = 1'b1;
    measure_period(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running simulation expected completion");
    $fatal(1, "timeout");
  end

endmodule
